// File: rtl/dmi_reg_responder.sv
// dmi_reg_responder
//
// Debug-module register responder. It accepts one-cycle DMI request strobes,
// decodes the low seven address bits and answers each accepted request with a
// one-cycle reg_ack two cycles after reg_en. Requests that arrive while a
// previous one is still in flight are dropped.
//
// Registers: data0 (0x04), data1 (0x05), dmcontrol (0x10), dmstatus (0x11),
// abstractcs (0x16) and command (0x17, write-only). A write to command
// launches an abstract command on cmd_valid/cmd_word, which stays pending
// until the core returns cmd_done.
//
// Optional feature: define DMI_RESP_TIMEOUT_EN to abandon a command that has
// been outstanding for CMD_TIMEOUT cycles (cmderr becomes 3). Without the
// macro a command stays pending until cmd_done.
//
// Ports:
//   core_clk, core_rst_n           clock (rising edge), async active-low reset
//   reg_en, reg_wr_en              request strobe and write qualifier
//   reg_wr_addr, reg_wr_data       request address ([6:0] decoded) and data
//   rd_data, reg_ack               read response and response strobe
//   core_halted                    halt status from the core
//   dm_haltreq, dm_resumereq,
//   dm_ndmreset                    debug control requests to the core
//   cmd_valid, cmd_word, cmd_done  abstract command handshake
module dmi_reg_responder #(
  parameter logic [15:0] CMD_TIMEOUT = 16'd1000
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        reg_en,
  input  logic        reg_wr_en,
  input  logic [31:0] reg_wr_addr,
  input  logic [31:0] reg_wr_data,
  output logic [31:0] rd_data,
  output logic        reg_ack,
  input  logic        core_halted,
  output logic        dm_haltreq,
  output logic        dm_resumereq,
  output logic        dm_ndmreset,
  output logic        cmd_valid,
  output logic [31:0] cmd_word,
  input  logic        cmd_done
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state;
  logic        req_wr;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [31:0] data0;
  logic [31:0] data1;
  logic        dmactive;
  logic [2:0]  cmderr;
  logic [31:0] rd_mux;

  // Only the low address bits select a register.
  logic unused_addr;
  assign unused_addr = ^reg_wr_addr[31:7];

`ifdef DMI_RESP_TIMEOUT_EN
  logic [15:0] cmd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^CMD_TIMEOUT;
`endif

  // Read view of the register map, evaluated against the latched address.
  always_comb begin
    rd_mux = 32'd0;
    case (req_addr)
      7'h04:   rd_mux = data0;
      7'h05:   rd_mux = data1;
      7'h10:   rd_mux = {dm_haltreq, dm_resumereq, 28'd0, dm_ndmreset, dmactive};
      7'h11:   rd_mux = {20'd0, ~core_halted, ~core_halted, core_halted, core_halted,
                         1'b1, 3'd0, 4'h2};
      7'h16:   rd_mux = {19'd0, cmd_valid, 1'b0, cmderr, 4'd0, 4'd2};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state        <= IDLE;
      req_wr       <= 1'b0;
      req_addr     <= 7'd0;
      req_data     <= 32'd0;
      rd_data      <= 32'd0;
      reg_ack      <= 1'b0;
      data0        <= 32'd0;
      data1        <= 32'd0;
      dmactive     <= 1'b0;
      dm_haltreq   <= 1'b0;
      dm_resumereq <= 1'b0;
      dm_ndmreset  <= 1'b0;
      cmderr       <= 3'd0;
      cmd_word     <= 32'd0;
      cmd_valid    <= 1'b0;
`ifdef DMI_RESP_TIMEOUT_EN
      cmd_cnt      <= 16'd0;
`endif
    end else begin
      reg_ack <= 1'b0;

      // The resume request is withdrawn as soon as the core reports running.
      if (dm_resumereq && !core_halted)
        dm_resumereq <= 1'b0;

      if (cmd_valid && cmd_done)
        cmd_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (reg_en) begin
            req_wr   <= reg_wr_en;
            req_addr <= reg_wr_addr[6:0];
            req_data <= reg_wr_data;
            state    <= ACCESS;
          end
        end

        ACCESS: begin
          state   <= ACK;
          reg_ack <= 1'b1;
          if (!req_wr) begin
            rd_data <= rd_mux;
          end else begin
            rd_data <= 32'd0;
            // dmcontrol stays writable so the module can be reactivated;
            // clearing dmactive drops all control requests with it.
            if (req_addr == 7'h10) begin
              dmactive    <= req_data[0];
              dm_haltreq  <= req_data[0] & req_data[31];
              dm_ndmreset <= req_data[0] & req_data[1];
              if (!req_data[0])
                dm_resumereq <= 1'b0;
              else if (req_data[30])
                dm_resumereq <= 1'b1;
            end else if (dmactive) begin
              case (req_addr)
                7'h04: begin
                  if (cmd_valid) begin
                    if (cmderr == 3'd0) cmderr <= 3'd1;
                  end else begin
                    data0 <= req_data;
                  end
                end
                7'h05: begin
                  if (cmd_valid) begin
                    if (cmderr == 3'd0) cmderr <= 3'd1;
                  end else begin
                    data1 <= req_data;
                  end
                end
                7'h16: cmderr <= cmderr & ~req_data[10:8];
                7'h17: begin
                  // A sticky error blocks new commands until software clears it.
                  if (cmderr == 3'd0) begin
                    if (cmd_valid) begin
                      cmderr <= 3'd1;
                    end else begin
                      cmd_word  <= req_data;
                      cmd_valid <= 1'b1;
`ifdef DMI_RESP_TIMEOUT_EN
                      cmd_cnt   <= 16'd0;
`endif
                    end
                  end
                end
                default: ;
              endcase
            end
          end
        end

        ACK: state <= IDLE;

        default: state <= IDLE;
      endcase

`ifdef DMI_RESP_TIMEOUT_EN
      // Evaluated last so an expiring command reports the timeout error even
      // if a busy write lands on the same edge.
      if (cmd_valid) begin
        if (cmd_cnt == CMD_TIMEOUT - 16'd1 && !cmd_done) begin
          cmd_valid <= 1'b0;
          cmderr    <= 3'd3;
        end else begin
          cmd_cnt <= cmd_cnt + 16'd1;
        end
      end
`endif
    end
  end

endmodule
